// File: rtl/aes_pkg.sv
// AES shared definitions: FSM states, GF(2^8) helpers, S-boxes, Rcon and
// the round/word-count derivations used by the inverse cipher.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_INIT,
        ST_ROUND
    } state_e;

    function automatic int unsigned nr_of(input int unsigned key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int unsigned words_of(input int unsigned key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] x;
        x = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(x);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_i marks the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [7:0]   sb [16];
    logic [127:0] ark;

    always_comb begin
        // Byte (row r, column c) sits at index 4c+r; row r takes column (c-r) mod 4.
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sb[4*c+r] = inv_sbox(state_i[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        for (int unsigned b = 0; b < 16; b++) begin
            ark[127-8*b -: 8] = sb[b] ^ rk_i[127-8*b -: 8];
        end
        state_o = ark;
        if (!last_i) begin
            for (int unsigned c = 0; c < 4; c++) begin
                state_o[127-32*c -: 8] = gf_mul(ark[127-32*c -: 8], 8'h0e) ^ gf_mul(ark[119-32*c -: 8], 8'h0b)
                                       ^ gf_mul(ark[111-32*c -: 8], 8'h0d) ^ gf_mul(ark[103-32*c -: 8], 8'h09);
                state_o[119-32*c -: 8] = gf_mul(ark[127-32*c -: 8], 8'h09) ^ gf_mul(ark[119-32*c -: 8], 8'h0e)
                                       ^ gf_mul(ark[111-32*c -: 8], 8'h0b) ^ gf_mul(ark[103-32*c -: 8], 8'h0d);
                state_o[111-32*c -: 8] = gf_mul(ark[127-32*c -: 8], 8'h0d) ^ gf_mul(ark[119-32*c -: 8], 8'h09)
                                       ^ gf_mul(ark[111-32*c -: 8], 8'h0e) ^ gf_mul(ark[103-32*c -: 8], 8'h0b);
                state_o[103-32*c -: 8] = gf_mul(ark[127-32*c -: 8], 8'h0b) ^ gf_mul(ark[119-32*c -: 8], 8'h0d)
                                       ^ gf_mul(ark[111-32*c -: 8], 8'h09) ^ gf_mul(ark[103-32*c -: 8], 8'h0e);
            end
        end
    end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES decryptor (FIPS-197 InvCipher): expands the key one word per
// cycle into a register array, then runs one inverse round per cycle.
module inv_cipher
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [127:0]        in,
    input  logic [KEY_BITS-1:0] key,
    output logic [127:0]        out,
    output logic                done,
    output logic                busy
);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("inv_cipher: KEY_BITS must be 128, 192 or 256");
    end

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = nr_of(KEY_BITS);
    localparam int unsigned NW = words_of(KEY_BITS);

    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_I = 6'(NW - 1);
    localparam logic [2:0] J_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_R   = 4'(NR);

    state_e       state_q, state_d;
    logic [127:0] in_q, in_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_q, out_d;
    logic         done_q, done_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   j_q, j_d;
    logic [3:0]   rc_q, rc_d;
    logic [3:0]   r_q, r_d;
    logic [31:0]  w_q [NW];
    logic [31:0]  w_d [NW];

    logic [5:0]   rk_base;
    logic [127:0] rk;
    logic [31:0]  prev_w, back_w, temp_w;
    logic         last_rnd;
    logic [127:0] rnd_out;

    always_comb begin
        rk_base = (state_q == ST_INIT) ? {NR_R, 2'b00} : {r_q, 2'b00};
        rk      = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end

    always_comb begin
        prev_w = w_q[i_q - 6'd1];
        back_w = w_q[i_q - NK_W];
        if (j_q == '0) begin
            temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon(rc_q), 24'h000000};
        end else if (NK == 8 && j_q == 3'd4) begin
            temp_w = sub_word(prev_w);
        end else begin
            temp_w = prev_w;
        end
    end

    assign last_rnd = (r_q == '0);

    aes_inv_round u_round (
        .state_i (st_q),
        .rk_i    (rk),
        .last_i  (last_rnd),
        .state_o (rnd_out)
    );

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        st_d    = st_q;
        out_d   = out_q;
        done_d  = 1'b0;
        i_d     = i_q;
        j_d     = j_q;
        rc_d    = rc_q;
        r_d     = r_q;
        w_d     = w_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    in_d = in;
                    for (int unsigned k = 0; k < NK; k++) begin
                        w_d[k] = key[KEY_BITS-1-32*k -: 32];
                    end
                    i_d     = NK_W;
                    j_d     = '0;
                    rc_d    = 4'd1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_d[i_q] = back_w ^ temp_w;
                i_d      = i_q + 6'd1;
                j_d      = (j_q == J_LAST) ? '0 : j_q + 3'd1;
                if (j_q == '0) rc_d = rc_q + 4'd1;
                if (i_q == LAST_I) state_d = ST_INIT;
            end
            ST_INIT: begin
                st_d    = in_q ^ rk;
                r_d     = NR_R - 4'd1;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (!last_rnd) begin
                    st_d = rnd_out;
                    r_d  = r_q - 4'd1;
                end else begin
                    out_d   = rnd_out;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            done_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            rc_q    <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rc_q    <= rc_d;
            r_q     <= r_d;
        end
    end

    // Datapath storage needs no reset: it is only consumed after a fresh load.
    always_ff @(posedge clk) begin
        in_q <= in_d;
        st_q <= st_d;
        w_q  <= w_d;
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher using the FIPS-197 example vectors for all
// three key sizes, plus busy-ignore, mid-run reset and back-to-back cases.
module tb_inv_cipher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start_a, start_b, start_c;
    logic [127:0] in_a, in_b, in_c;
    logic [127:0] key_a;
    logic [191:0] key_b;
    logic [255:0] key_c;
    logic [127:0] out_a, out_b, out_c;
    logic         done_a, done_b, done_c;
    logic         busy_a, busy_b, busy_c;

    inv_cipher #(.KEY_BITS(128)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in(in_a), .key(key_a),
        .out(out_a), .done(done_a), .busy(busy_a)
    );
    inv_cipher #(.KEY_BITS(192)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in(in_b), .key(key_b),
        .out(out_b), .done(done_b), .busy(busy_b)
    );
    inv_cipher #(.KEY_BITS(256)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .in(in_c), .key(key_c),
        .out(out_c), .done(done_c), .busy(busy_c)
    );

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] K_128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K_192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K_256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    int errors = 0;
    int checks = 0;
    int lat;

    task automatic check_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Single-cycle start pulse; returns just after the accepting edge.
    task automatic launch(input int sel);
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
    endtask

    // Counts edges until done (lat = -1 if the budget expires).
    // act 1: at act_edge disturb in/key of dut_a and pulse its start.
    // act 2: at act_edge assert reset for three edges.
    task automatic wait_done(input int sel, input int budget, input int act,
                             input int act_edge, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            if (act == 1 && n + 1 == act_edge) begin
                in_a    = ~CT_128;
                key_a   = ~K_128;
                start_a = 1'b1;
            end
            if (act == 2 && n + 1 == act_edge) reset = 1'b1;
            tick();
            n++;
            if (act == 1 && n == act_edge) begin
                start_a = 1'b0;
                check_v("busy_at_ignored_start", 128'(busy_a), 128'(1'b1));
            end
            if (act == 2 && n == act_edge) begin
                check_v("out_after_abort", out_a, '0);
                check_v("busy_after_abort", 128'(busy_a), '0);
                check_v("done_after_abort", 128'(done_a), '0);
            end
            if (act == 2 && n == act_edge + 2) reset = 1'b0;
            if (done_of(sel)) found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        in_a    = CT_128; in_b = CT_192; in_c = CT_256;
        key_a   = K_128;  key_b = K_192; key_c = K_256;
        tick(); tick(); tick();
        reset = 1'b0;

        check_v("rst_out_128",  out_a, '0);
        check_v("rst_done_128", 128'(done_a), '0);
        check_v("rst_busy_128", 128'(busy_a), '0);
        check_v("rst_out_192",  out_b, '0);
        check_v("rst_done_192", 128'(done_b), '0);
        check_v("rst_busy_192", 128'(busy_b), '0);
        check_v("rst_out_256",  out_c, '0);
        check_v("rst_done_256", 128'(done_c), '0);
        check_v("rst_busy_256", 128'(busy_c), '0);
        tick();

        // Basic 128-bit decryption with timing and handshake details.
        launch(0);
        check_v("busy_after_accept_128", 128'(busy_a), 128'(1'b1));
        wait_done(0, 100, 0, 0, lat);
        check_i("latency_128", lat, 51);
        check_v("pt_128", out_a, PT);
        check_v("busy_at_done_128", 128'(busy_a), '0);
        tick();
        check_v("done_one_cycle_128", 128'(done_a), '0);
        tick(); tick();
        check_v("out_hold_128", out_a, PT);

        launch(1);
        wait_done(1, 100, 0, 0, lat);
        check_i("latency_192", lat, 59);
        check_v("pt_192", out_b, PT);

        launch(2);
        wait_done(2, 100, 0, 0, lat);
        check_i("latency_256", lat, 67);
        check_v("pt_256", out_c, PT);
        tick();

        // Start and new in/key while busy must not disturb the run.
        launch(0);
        wait_done(0, 100, 1, 20, lat);
        check_i("latency_ignore_start", lat, 51);
        check_v("pt_ignore_start", out_a, PT);
        in_a  = CT_128;
        key_a = K_128;
        tick();
        check_v("no_restart_after_ignored", 128'(busy_a), '0);

        // Mid-run reset aborts without done; a fresh start completes.
        launch(0);
        wait_done(0, 80, 2, 30, lat);
        check_i("no_done_after_abort", lat, -1);
        check_v("out_zero_after_abort", out_a, '0);
        launch(0);
        wait_done(0, 100, 0, 0, lat);
        check_i("latency_restart", lat, 51);
        check_v("pt_restart", out_a, PT);
        tick();

        // Start held high: second operation accepted one edge after done.
        start_a = 1'b1;
        tick();
        wait_done(0, 100, 0, 0, lat);
        check_i("latency_b2b_first", lat, 51);
        check_v("pt_b2b_first", out_a, PT);
        wait_done(0, 100, 0, 0, lat);
        start_a = 1'b0;
        check_i("spacing_b2b", lat, 52);
        check_v("pt_b2b_second", out_a, PT);
        tick();
        check_v("idle_after_b2b", 128'(busy_a), '0);
        check_v("done_low_after_b2b", 128'(done_a), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_cipher.md
INV_CIPHER -- requirements
Module: inv_cipher

Interface
REQ-001 KEY_BITS, default 128, AES key length in bits; legal values 128, 192 and 256; any other value SHALL cause an elaboration error.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a decryption; sampled only while busy=0.
REQ-005 in  input  128  ciphertext block, FIPS-197 byte order (byte 0 = bits 127:120).
REQ-006 key  input  KEY_BITS  cipher key, FIPS-197 byte order.
REQ-007 out  output  128  plaintext block, registered.
REQ-008 done  output  1  one-cycle pulse, out valid and updated.
REQ-009 busy  output  1  high from the edge accepting start until the edge raising done, inclusive.

Function
REQ-010 Algorithm SHALL be the FIPS-197 InvCipher (not the equivalent inverse cipher), Nk=KEY_BITS/32, Nr=Nk+6, total words W=4*(Nr+1).
REQ-011 States: IDLE, EXPAND, INIT, ROUND.
REQ-012 IDLE with start=1: latch in and key, load w[0..Nk-1] from key, set index i=Nk, busy=1, go to EXPAND.
REQ-013 EXPAND: one word w[i] per cycle, w[i]=w[i-Nk]^temp, temp = SubWord(RotWord(w[i-1]))^Rcon[i/Nk] when i mod Nk=0, SubWord(w[i-1]) when Nk=8 and i mod 8=4, else w[i-1]; after w[W-1], go to INIT.
REQ-014 INIT: state = latched in XOR round key Nr (w[4Nr..4Nr+3]); round counter r=Nr-1; go to ROUND.
REQ-015 ROUND (r>0): state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])); decrement r.
REQ-016 ROUND (r=0): out = AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]); done=1 for that cycle; busy=0; go to IDLE.
REQ-017 Latency, start-accept edge to done-high edge: (W-Nk)+1+Nr edges = 51 (128), 59 (192), 67 (256).
REQ-018 start while busy=1 SHALL be ignored; in/key changes while busy SHALL NOT affect the result.
REQ-019 start asserted in the same cycle done pulses SHALL be ignored; it is accepted the following cycle if still high.
REQ-020 out SHALL hold its value between done pulses; back-to-back operations SHALL each produce an independent correct result.
REQ-021 GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; InvMixColumns matrix rows {0e,0b,0d,09} rotated.

Reset
REQ-022 reset=1 SHALL force state IDLE, out=0, done=0, busy=0, counters 0 on the next rising edge, overriding start.
REQ-023 reset mid-operation SHALL abort the operation with no done pulse; a new start after reset deasserts SHALL complete normally.

Structure
REQ-024 Shared package aes_pkg SHALL hold the forward S-box function (key schedule), the inverse S-box function, xtime/gf_mul, the Rcon table and the Nr/W derivation constants.
REQ-025 One combinational sub-module aes_inv_round (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns via a last-round flag) SHALL be used; key expansion and the FSM stay in inv_cipher.
REQ-026 Key words SHALL be stored in a register array of W×32 bits; there SHALL be no latches and no combinational path from in/key to out.

Verification
REQ-027 KEY_BITS=128, key 000102…0f, in 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done at edge 51, out=00112233445566778899aabbccddeeff.
REQ-028 KEY_BITS=192, key 000102…17, in dda97ca4864cdfe06eaf70a0ec0d7191 -> done at edge 59, out=00112233445566778899aabbccddeeff.
REQ-029 KEY_BITS=256, key 000102…1f, in 8ea2b7ca516745bfeafc49904b496089 -> done at edge 67, out=00112233445566778899aabbccddeeff.
REQ-030 128-bit case: change in/key and pulse start at edge 20 -> ignored, same result and timing as REQ-027.
REQ-031 Assert reset at edge 30 of a 128-bit run -> no done pulse, out=0, busy=0; restart -> REQ-027 result.
REQ-032 Two back-to-back 128-bit operations, start held high -> two done pulses 52 edges apart, both with the correct plaintext.
